// File: rtl/axis_dwc_defs.sv
// Shared definitions for the AXIS width downsizer.
// Width helpers and parameter legality predicates.
package axis_dwc_defs;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int dwc_ratio(input int s_w, input int m_w);
    return s_w / m_w;
  endfunction

  function automatic int dwc_seg_w(input int ratio);
    return (ratio < 2) ? 1 : clog2(ratio);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit dwc_legal(
    input int s_w, input int m_w,
    input int u_w, input int dly
  );
    int r;
    if (m_w <= 0) return 1'b0;
    r = s_w / m_w;
    return (s_w % 8 == 0) && (m_w % 8 == 0) &&
           (s_w % m_w == 0) && is_pow2(r) &&
           (r >= 2) && (u_w >= 1) && (dly >= 0);
  endfunction

endpackage

// File: rtl/axis_dwc_last_seg_finder.sv
// Finds the highest wide-beat segment with any keep bit set.
// Segment 0 is reported when keep is entirely zero.
module axis_dwc_last_seg_finder
  import axis_dwc_defs::*;
#(
  parameter int ratio  = 4,
  parameter int kw     = 2,
  parameter int seg_w  = 2
) (
  input  logic [ratio-1:0][kw-1:0] i_keep,
  output logic [seg_w-1:0]         o_final_seg
);

  // priority encoder: later (higher) segments override lower ones
  always_comb begin
    o_final_seg = '0;
    for (int k = 0; k < ratio; k++) begin
      if (|i_keep[k]) o_final_seg = seg_w'(k);
    end
  end

endmodule

// File: rtl/axis_data_width_downsizer.sv
// AXIS width downsizer: wide beats out as LS-first narrow beats.
// AXIS_DWC_SKIP_NULL_SEG_EN: drop trailing all-zero-keep segments.
module axis_data_width_downsizer
  import axis_dwc_defs::*;
#(
  parameter int s_data_width     = 64,
  parameter int m_data_width     = 16,
  parameter int user_width       = 1,
  parameter int simulation_delay = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [s_data_width-1:0]   s_axis_data,
  input  logic [s_data_width/8-1:0] s_axis_keep,
  input  logic [user_width-1:0]     s_axis_user,
  input  logic                      s_axis_last,
  input  logic                      s_axis_valid,
  output logic                      s_axis_ready,
  output logic [m_data_width-1:0]   m_axis_data,
  output logic [m_data_width/8-1:0] m_axis_keep,
  output logic [user_width-1:0]     m_axis_user,
  output logic                      m_axis_last,
  output logic                      m_axis_valid,
  input  logic                      m_axis_ready
);

  localparam int RATIO = dwc_ratio(s_data_width, m_data_width);
  localparam int SEG_W = dwc_seg_w(RATIO);
  localparam int MKW   = m_data_width / 8;

  if (!dwc_legal(s_data_width, m_data_width,
                 user_width, simulation_delay)) begin : g_bad_cfg
    $error("axis_data_width_downsizer: illegal parameters");
  end

  logic [RATIO-1:0][m_data_width-1:0] r_data;
  logic [RATIO-1:0][MKW-1:0]          r_keep;
  logic [user_width-1:0]              r_user;
  logic                               r_last;
  logic                               r_vld;
  logic [SEG_W-1:0]                   r_seg;

  logic [SEG_W-1:0] w_final;
  logic             w_at_final;
  logic             w_s_hs;
  logic             w_m_hs;

`ifdef AXIS_DWC_SKIP_NULL_SEG_EN
  logic [SEG_W-1:0] w_final_in;
  logic [SEG_W-1:0] r_final;

  axis_dwc_last_seg_finder #(
    .ratio (RATIO),
    .kw    (MKW),
    .seg_w (SEG_W)
  ) u_finder (
    .i_keep      (s_axis_keep),
    .o_final_seg (w_final_in)
  );

  // final segment index latched with each wide beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_final <= '0;
    else if (w_s_hs) r_final <= w_final_in;
  end

  assign w_final = r_final;
`else
  assign w_final = SEG_W'(RATIO - 1);
`endif

  assign w_at_final   = (r_seg == w_final);
  assign s_axis_ready = ~r_vld | (m_axis_ready & w_at_final);
  assign w_s_hs       = s_axis_valid & s_axis_ready;
  assign w_m_hs       = r_vld & m_axis_ready;

  assign m_axis_valid = r_vld;
  assign m_axis_data  = r_data[r_seg];
  assign m_axis_keep  = r_keep[r_seg];
  assign m_axis_user  = r_user;
  assign m_axis_last  = r_last & w_at_final;

  // hold register and segment walk; a new load beats the final drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_keep <= '0;
      r_user <= '0;
      r_last <= 1'b0;
      r_vld  <= 1'b0;
      r_seg  <= '0;
    end else if (w_s_hs) begin
      r_data <= s_axis_data;
      r_keep <= s_axis_keep;
      r_user <= s_axis_user;
      r_last <= s_axis_last;
      r_vld  <= 1'b1;
      r_seg  <= '0;
    end else if (w_m_hs) begin
      if (w_at_final) r_vld <= 1'b0;
      else            r_seg <= r_seg + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_data_width_downsizer.sv
// Directed bench for the 64->16 AXIS width downsizer.
// Expectations follow AXIS_DWC_SKIP_NULL_SEG_EN when defined.
module tb_axis_data_width_downsizer;

  logic        clk;
  logic        rst_n;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic [0:0]  s_user;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] m_data;
  logic [1:0]  m_keep;
  logic [0:0]  m_user;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;

  int n_tests = 0;
  int n_fail  = 0;

  axis_data_width_downsizer #(
    .s_data_width     (64),
    .m_data_width     (16),
    .user_width       (1),
    .simulation_delay (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_data  (s_data),
    .s_axis_keep  (s_keep),
    .s_axis_user  (s_user),
    .s_axis_last  (s_last),
    .s_axis_valid (s_valid),
    .s_axis_ready (s_ready),
    .m_axis_data  (m_data),
    .m_axis_keep  (m_keep),
    .m_axis_user  (m_user),
    .m_axis_last  (m_last),
    .m_axis_valid (m_valid),
    .m_axis_ready (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]      d;
    logic [7:0]       k;
    logic             u;
    logic             l;
    logic [2:0]       n;
    logic [3:0][15:0] ed;
    logic [3:0][1:0]  ek;
  } vec_t;

  vec_t vt [5];

  logic [63:0] sb_d [3];
  logic [7:0]  sb_k [3];
  logic        sb_l [3];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vt[i];
    @(negedge clk);
    s_data  = v.d;
    s_keep  = v.k;
    s_user  = v.u;
    s_last  = v.l;
    s_valid = 1'b1;
    m_ready = 1'b1;
    #1;
    chk($sformatf("vec%0d s_ready", i), 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    for (int b = 0; b < int'(v.n); b++) begin
      @(negedge clk);
      chk($sformatf("vec%0d beat%0d", i, b),
          64'({m_valid, m_data, m_keep, m_user, m_last}),
          64'({1'b1, v.ed[b], v.ek[b], v.u,
               v.l && (b == int'(v.n) - 1)}));
    end
    @(negedge clk);
    chk($sformatf("vec%0d drained", i), 64'(m_valid), 64'd0);
  endtask

  task automatic run_stream(input bit rnd);
    int sent  = 0;
    int got   = 0;
    int cyc   = 0;
    int first = -1;
    int lastc = -1;
    bit stall = 1'b0;
    logic [19:0] prev = '0;
    logic [15:0] ew;
    logic [1:0]  ek;
    logic [63:0] wd;
    logic [7:0]  wk;
    while (got < 12 && cyc < 400) begin
      @(negedge clk);
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = (sent < 3);
      s_data  = (sent < 3) ? sb_d[sent] : 64'd0;
      s_keep  = (sent < 3) ? sb_k[sent] : 8'd0;
      s_last  = (sent < 3) ? sb_l[sent] : 1'b0;
      s_user  = 1'b0;
      #1;
      if (stall)
        chk("stall hold", 64'({m_valid, m_data, m_keep, m_last}),
            64'(prev));
      if (m_valid && m_ready) begin
        wd = sb_d[got / 4];
        wk = sb_k[got / 4];
        ew = wd[(got % 4) * 16 +: 16];
        ek = wk[(got % 4) * 2 +: 2];
        chk($sformatf("stream beat%0d", got),
            64'({m_data, m_keep, m_last}),
            64'({ew, ek, sb_l[got / 4] && (got % 4 == 3)}));
        if (!rnd)
          chk($sformatf("b2b s_ready%0d", got), 64'(s_ready),
              64'(got % 4 == 3));
        if (first < 0) first = cyc;
        lastc = cyc;
        got++;
      end
      stall = m_valid && !m_ready;
      prev  = {1'b1, m_data, m_keep, m_last};
      if (s_valid && s_ready) sent++;
      cyc++;
    end
    chk("stream beat count", 64'(got), 64'd12);
    if (!rnd) chk("b2b no idle", 64'(lastc - first), 64'd11);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    vt[0] = {64'h4444_3333_2222_1111, 8'hFF, 1'b1, 1'b1, 3'd4,
             {16'h4444, 16'h3333, 16'h2222, 16'h1111},
             {2'd3, 2'd3, 2'd3, 2'd3}};
    vt[1] = {64'hDEAD_BEEF_0123_4567, 8'hA5, 1'b0, 1'b0, 3'd4,
             {16'hDEAD, 16'hBEEF, 16'h0123, 16'h4567},
             {2'd2, 2'd2, 2'd1, 2'd1}};
`ifdef AXIS_DWC_SKIP_NULL_SEG_EN
    vt[2] = {64'h8888_7777_6666_5555, 8'h0F, 1'b0, 1'b1, 3'd2,
             {16'h8888, 16'h7777, 16'h6666, 16'h5555},
             {2'd0, 2'd0, 2'd3, 2'd3}};
    vt[3] = {64'hCAFE_F00D_1234_ABCD, 8'h00, 1'b1, 1'b1, 3'd1,
             {16'hCAFE, 16'hF00D, 16'h1234, 16'hABCD},
             {2'd0, 2'd0, 2'd0, 2'd0}};
    vt[4] = {64'h0000_9999_0000_0000, 8'h30, 1'b1, 1'b1, 3'd3,
             {16'h0000, 16'h9999, 16'h0000, 16'h0000},
             {2'd0, 2'd3, 2'd0, 2'd0}};
`else
    vt[2] = {64'h8888_7777_6666_5555, 8'h0F, 1'b0, 1'b1, 3'd4,
             {16'h8888, 16'h7777, 16'h6666, 16'h5555},
             {2'd0, 2'd0, 2'd3, 2'd3}};
    vt[3] = {64'hCAFE_F00D_1234_ABCD, 8'h00, 1'b1, 1'b1, 3'd4,
             {16'hCAFE, 16'hF00D, 16'h1234, 16'hABCD},
             {2'd0, 2'd0, 2'd0, 2'd0}};
    vt[4] = {64'h0000_9999_0000_0000, 8'h30, 1'b1, 1'b1, 3'd4,
             {16'h0000, 16'h9999, 16'h0000, 16'h0000},
             {2'd0, 2'd3, 2'd0, 2'd0}};
`endif

    rst_n   = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_user  = '0;
    s_last  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out", 64'({m_valid, m_last, m_data, m_keep, m_user}),
        64'd0);
    chk("reset s_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(i);

    sb_d[0] = 64'h1003_1002_1001_1000;
    sb_d[1] = 64'h2003_2002_2001_2000;
    sb_d[2] = 64'h3003_3002_3001_3000;
    for (int j = 0; j < 3; j++) begin
      sb_k[j] = 8'hFF;
      sb_l[j] = (j == 2);
    end
    run_stream(1'b0);

    for (int j = 0; j < 3; j++) begin
      sb_d[j] = {$urandom, $urandom};
      sb_l[j] = 1'($urandom_range(0, 1));
    end
    run_stream(1'b1);

    @(negedge clk);
    s_data  = 64'hAAAA_BBBB_CCCC_DDDD;
    s_keep  = 8'hFF;
    s_last  = 1'b1;
    s_valid = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset beat0", 64'({m_valid, m_data}), 64'({1'b1, 16'hDDDD}));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset out", 64'({m_valid, m_last, m_data, m_keep}), 64'd0);
    chk("mid reset s_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post reset idle%0d", c),
          64'({m_valid, m_last}), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
